// File: rtl/demux_pkg.sv
// demux_pkg: shared types and widths for the two-channel demux capture block.
package demux_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic {
        WAIT_X = 1'b0,
        WAIT_Y = 1'b1
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer followed by a rising-edge detector on the synchronized level.
module sync_edge (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic async_in,
    output logic pulse_out
);

    logic s1, s2, s3;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse_out = s2 & ~s3;

endmodule

// File: rtl/demux2_capture.sv
// demux2_capture: captures an X-then-Y word pair from a strobed multiplexed bus,
// flagging out-of-order tags and counting completed pairs.
module demux2_capture
    import demux_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [W-1:0]     M_in,
    input  logic             s_in,
    input  logic             strobe_in,
    input  logic             clr,
    output logic [W-1:0]     X_out,
    output logic [W-1:0]     Y_out,
    output logic             pair_valid,
    output logic             seq_err,
    output logic [CNT_W-1:0] pair_cnt,
    output logic             state_o
);

    state_t           state, state_nx;
    logic             ev, take_x, take_y, bad;
    logic [W-1:0]     x_nx, y_nx;
    logic             pv_nx, err_nx;
    logic [CNT_W-1:0] cnt_nx;

    sync_edge u_sync (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .async_in  (strobe_in),
        .pulse_out (ev)
    );

    // An X tag always (re)loads X_out; a tag that disagrees with the awaited channel is an error.
    assign take_x = ev & ~s_in;
    assign take_y = ev & s_in & (state == WAIT_Y);
    assign bad    = ev & (s_in ^ (state == WAIT_Y));

    always_comb begin
        state_nx = take_x ? WAIT_Y : take_y ? WAIT_X : state;
        x_nx     = take_x ? M_in : X_out;
        y_nx     = take_y ? M_in : Y_out;
        pv_nx    = take_y;
        err_nx   = bad | (seq_err & ~clr);
        cnt_nx   = (clr ? '0 : pair_cnt) + (take_y ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= WAIT_X;
            X_out      <= '0;
            Y_out      <= '0;
            pair_valid <= 1'b0;
            seq_err    <= 1'b0;
            pair_cnt   <= '0;
        end else begin
            state      <= state_nx;
            X_out      <= x_nx;
            Y_out      <= y_nx;
            pair_valid <= pv_nx;
            seq_err    <= err_nx;
            pair_cnt   <= cnt_nx;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_demux2_capture.sv
// tb_demux2_capture: directed checks of pair capture, sequencing errors, wrap, clear and reset.
module tb_demux2_capture;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] M_in = '0;
    logic       s_in = 1'b0;
    logic       strobe_in = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] X_out, Y_out, pair_cnt;
    logic       pair_valid, seq_err, state_o;

    int n_tests = 0;
    int n_fail = 0;
    int pv_seen = 0;
    int base;

    demux2_capture #(.W(4)) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .M_in       (M_in),
        .s_in       (s_in),
        .strobe_in  (strobe_in),
        .clr        (clr),
        .X_out      (X_out),
        .Y_out      (Y_out),
        .pair_valid (pair_valid),
        .seq_err    (seq_err),
        .pair_cnt   (pair_cnt),
        .state_o    (state_o)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) if (pair_valid === 1'b1) pv_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] x, input logic [3:0] y,
                           input logic [3:0] cnt, input logic err, input logic st);
        chk({tag, "_x"}, X_out, x);
        chk({tag, "_y"}, Y_out, y);
        chk({tag, "_cnt"}, pair_cnt, cnt);
        chk({tag, "_err"}, seq_err, err);
        chk({tag, "_state"}, state_o, st);
    endtask

    // Sender protocol: data stable 3 cycles, then strobe; optional clr aligned to the capture edge.
    task automatic send(input logic [3:0] m, input logic s, input logic exp_pv, input logic c);
        @(negedge CLOCK_50);
        M_in = m;
        s_in = s;
        repeat (3) @(negedge CLOCK_50);
        strobe_in = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        chk("pv_early", pair_valid, 1'b0);
        clr = c;
        @(negedge CLOCK_50);
        clr = 1'b0;
        chk("pv_edge3", pair_valid, exp_pv);
        @(negedge CLOCK_50);
        chk("pv_width", pair_valid, 1'b0);
        strobe_in = 1'b0;
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        resetn = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
        @(negedge CLOCK_50);
    endtask

    initial begin
        repeat (2) @(negedge CLOCK_50);
        chk("rst_pv", pair_valid, 1'b0);
        chk_all("rst", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        resetn = 1'b1;
        @(negedge CLOCK_50);

        // basic pair
        base = pv_seen;
        send(4'h5, 1'b0, 1'b0, 1'b0);
        chk_all("basic_x", 4'h5, 4'h0, 4'h0, 1'b0, 1'b1);
        send(4'hA, 1'b1, 1'b1, 1'b0);
        chk_all("basic_y", 4'h5, 4'hA, 4'h1, 1'b0, 1'b0);
        chk("basic_pulses", pv_seen - base, 1);

        // out-of-order Y first
        do_reset();
        send(4'h3, 1'b1, 1'b0, 1'b0);
        chk_all("ooo_err", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        send(4'h1, 1'b0, 1'b0, 1'b0);
        send(4'h2, 1'b1, 1'b1, 1'b0);
        chk_all("ooo_pair", 4'h1, 4'h2, 4'h1, 1'b1, 1'b0);

        // resync on a second X
        do_reset();
        send(4'h4, 1'b0, 1'b0, 1'b0);
        send(4'h7, 1'b0, 1'b0, 1'b0);
        chk_all("resync", 4'h7, 4'h0, 4'h0, 1'b1, 1'b1);
        send(4'h9, 1'b1, 1'b1, 1'b0);
        chk_all("resync_pair", 4'h7, 4'h9, 4'h1, 1'b1, 1'b0);

        // 16 pairs wrap the counter; then clear alone and clear coincident with events
        do_reset();
        send(4'h3, 1'b1, 1'b0, 1'b0);
        base = pv_seen;
        for (int i = 0; i < 16; i++) begin
            send(4'(i), 1'b0, 1'b0, 1'b0);
            send(4'(15 - i), 1'b1, 1'b1, 1'b0);
            if (i == 14) chk("cnt15", pair_cnt, 4'hF);
        end
        chk_all("wrap", 4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
        chk("wrap_pulses", pv_seen - base, 16);
        send(4'h2, 1'b0, 1'b0, 1'b0);
        send(4'h6, 1'b0, 1'b0, 1'b0);
        send(4'hB, 1'b1, 1'b1, 1'b1);
        chk_all("clr_pair", 4'h6, 4'hB, 4'h1, 1'b0, 1'b0);
        send(4'h3, 1'b0, 1'b0, 1'b0);
        @(negedge CLOCK_50);
        clr = 1'b1;
        @(negedge CLOCK_50);
        clr = 1'b0;
        chk_all("clr_alone", 4'h3, 4'hB, 4'h0, 1'b0, 1'b1);
        send(4'hD, 1'b0, 1'b0, 1'b1);
        chk_all("clr_err", 4'hD, 4'hB, 4'h0, 1'b1, 1'b1);

        // long strobe gives one capture at edge 3, then async reset mid-pair
        do_reset();
        send(4'h1, 1'b0, 1'b0, 1'b0);
        send(4'h2, 1'b1, 1'b1, 1'b0);
        @(negedge CLOCK_50);
        M_in = 4'h8;
        s_in = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        strobe_in = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        chk("long_edge2_x", X_out, 4'h1);
        @(negedge CLOCK_50);
        chk("long_edge3_x", X_out, 4'h8);
        chk("long_edge3_state", state_o, 1'b1);
        repeat (17) @(negedge CLOCK_50);
        chk_all("long_hold", 4'h8, 4'h2, 4'h1, 1'b0, 1'b1);
        strobe_in = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_pv", pair_valid, 1'b0);
        chk_all("midrst", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        base = pv_seen;
        send(4'hE, 1'b1, 1'b0, 1'b0);
        chk_all("after_rst_y", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        chk("after_rst_pulses", pv_seen - base, 0);

        // strobe already high when reset releases
        @(negedge CLOCK_50);
        resetn = 1'b0;
        M_in = 4'hC;
        s_in = 1'b0;
        strobe_in = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        chk("rel_edge2_x", X_out, 4'h0);
        @(negedge CLOCK_50);
        chk("rel_edge3_x", X_out, 4'hC);
        chk("rel_edge3_state", state_o, 1'b1);
        strobe_in = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux2_capture.md
DEMUX2_CAPTURE -- requirements
Module: demux2_capture

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: CLOCK_50 clocks all state; resetn low resets all state immediately, regardless of the clock.
REQ-002 The block SHALL have parameter W, default 4, meaning the data width of each channel.
REQ-003 The block SHALL have the following ports:
- CLOCK_50, input, 1: system clock; all state updates on the rising edge.
- resetn, input, 1: asynchronous, active-low reset.
- M_in, input, W: multiplexed data word from the sender.
- s_in, input, 1: channel tag for M_in; 0 = X, 1 = Y.
- strobe_in, input, 1: word-present level from the sender; asynchronous to CLOCK_50.
- clr, input, 1: synchronous clear of the error flag and the pair counter.
- X_out, output, W: last captured X word.
- Y_out, output, W: last captured Y word.
- pair_valid, output, 1: one-cycle pulse when a complete X-then-Y pair has been captured.
- seq_err, output, 1: sticky sequence-error flag.
- pair_cnt, output, 4: count of completed pairs.
- state_o, output, 1: current FSM state; 0 = WAIT_X, 1 = WAIT_Y.

Function
REQ-004 strobe_in SHALL pass through a 2-flop synchronizer; an event SHALL be the cycle in which the synchronized level is 1 and its previous-cycle value is 0.
REQ-005 On an event, M_in and s_in SHALL be sampled directly; the sender holds both stable from 3 cycles before the strobe_in rise until strobe_in falls.
REQ-006 Event-to-capture latency SHALL be 3 rising edges after the strobe_in rise: 2 synchronizer edges plus the capture edge.
REQ-007 A strobe_in high for N cycles SHALL produce exactly one event; a new event requires strobe_in to be low for at least 2 cycles first.
REQ-008 In WAIT_X, an event with s_in=0 SHALL load X_out with M_in and move the FSM to WAIT_Y.
REQ-009 In WAIT_X, an event with s_in=1 SHALL leave X_out and Y_out unchanged, set seq_err, and keep the FSM in WAIT_X.
REQ-010 In WAIT_Y, an event with s_in=1 SHALL, on the same edge:
- load Y_out with M_in;
- assert pair_valid for exactly the following cycle;
- increment pair_cnt modulo 16, wrapping 15 -> 0;
- move the FSM to WAIT_X.
REQ-011 In WAIT_Y, an event with s_in=0 SHALL overwrite X_out with M_in (resynchronize), set seq_err, and keep the FSM in WAIT_Y.
REQ-012 X_out and Y_out SHALL hold their values between captures; pair_valid SHALL be low in every cycle not given by REQ-010.
REQ-013 When clr and an event coincide, clr SHALL apply first: the event's capture and FSM update proceed, seq_err ends up as the event's error result, and pair_cnt ends up 1 if the event completes a pair, otherwise 0.
REQ-014 clr SHALL NOT change the FSM state, X_out, or Y_out.

Reset
REQ-015 While resetn is low, the block SHALL hold: X_out=0, Y_out=0, pair_valid=0, seq_err=0, pair_cnt=0, FSM=WAIT_X, both synchronizer flops and the edge-history flop at 0.
REQ-016 A reset asserted between the X and Y captures SHALL abandon the partial pair, with no pair_valid and pair_cnt=0.
REQ-017 A strobe_in already high when resetn rises SHALL produce one event, 3 edges after resetn rises.

Structure
REQ-018 A shared package demux_pkg SHALL hold the state enum (WAIT_X=0, WAIT_Y=1), the default width W=4, and the pair_cnt width 4.
REQ-019 The 2-flop synchronizer plus rising-edge detector SHALL be a separate sub-module, sync_edge, with ports CLOCK_50, resetn, async_in, and pulse_out.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Basic pair: after reset, strobe X=0x5 (s=0), then Y=0xA (s=1) -> X_out=0x5, Y_out=0xA, one pair_valid pulse, pair_cnt=1, seq_err=0.
- Out-of-order: after reset, strobe s=1 with M=0x3 -> seq_err=1, Y_out=0, state stays WAIT_X; a following X=0x1 then Y=0x2 -> pair_valid, pair_cnt=1, seq_err stays 1.
- Resync: strobe X=0x4, then X=0x7 (s=0) -> seq_err=1, X_out=0x7, state WAIT_Y; then Y=0x9 -> pair_valid, X_out=0x7, Y_out=0x9.
- Wrap and clear: 16 valid pairs -> pair_cnt=0 after the 16th with 16 pair_valid pulses; clr coincident with the completing event of a 17th pair -> pair_cnt=1, seq_err=0.
- Long strobe and reset mid-pair: strobe_in high for 20 cycles -> exactly one capture at edge 3; resetn pulsed low between X and Y (async, off-edge) -> all outputs 0 immediately, no pair_valid.
